// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter driven instruction fetch front end.
// It issues in-order fetch requests under a credit limit, tags each
// accepted request with its PC, buffers returned words with their PCs,
// and discards stale responses after a redirect or restart.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_pc,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_addr,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_W-1:0]        inst_data,
  output logic [ADDR_W-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);
  localparam logic [CNT_W:0]    DEPTH_L = (CNT_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  discard_q;

  // Tag queue: PCs of accepted requests awaiting their responses.
  logic [ADDR_W-1:0] tag_q [DEPTH];
  logic [PTR_W-1:0]  tag_wr_q;
  logic [PTR_W-1:0]  tag_rd_q;

  // Instruction buffer: returned words together with their PCs.
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [ADDR_W-1:0] buf_pc_q   [DEPTH];
  logic [PTR_W-1:0]  buf_wr_q;
  logic [PTR_W-1:0]  buf_rd_q;
  logic [CNT_W-1:0]  buf_cnt_q;

  logic             credit_ok;
  logic             accept;
  logic             rsp_ok;
  logic             rsp_keep;
  logic             pop;
  logic             flush;
  logic [CNT_W-1:0] outst_d;

  // Requests in flight plus buffered words may never exceed the buffer size.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_cnt_q}) < DEPTH_L;

  // A restart is honoured in any state; a redirect only while fetching.
  assign flush    = load_pc | (redirect & (state_q == RUN));
  assign accept   = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol error and is dropped.
  assign rsp_ok   = imem_rvalid & (outstanding_q != '0);
  assign rsp_keep = rsp_ok & (discard_q == '0) & ~flush;
  assign pop      = inst_valid & inst_ready;
  assign outst_d  = outstanding_q + CNT_W'(accept) - CNT_W'(rsp_ok);

  assign imem_addr   = pc_q;
  assign outstanding = outstanding_q;
  assign inst_valid  = (buf_cnt_q != '0);
  assign inst_data   = buf_data_q[buf_rd_q];
  assign inst_pc     = buf_pc_q[buf_rd_q];

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and request generation.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_pc) begin
          state_d = RUN;
        end
      end
      RUN: begin
        imem_req = credit_ok;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // PC, outstanding/discard counters and queue pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      buf_wr_q      <= '0;
      buf_rd_q      <= '0;
      buf_cnt_q     <= '0;
    end else begin
      if (load_pc) begin
        pc_q <= load_addr;
      end else if (redirect && (state_q == RUN)) begin
        pc_q <= redirect_addr;
      end else if (accept) begin
        pc_q <= pc_q + PC_STEP;
      end

      outstanding_q <= outst_d;

      if (accept) begin
        tag_wr_q <= tag_wr_q + PTR_W'(1);
      end
      if (rsp_ok) begin
        tag_rd_q <= tag_rd_q + PTR_W'(1);
      end

      if (flush) begin
        discard_q <= outst_d;
      end else if (rsp_ok && (discard_q != '0)) begin
        discard_q <= discard_q - CNT_W'(1);
      end

      if (flush) begin
        buf_wr_q  <= '0;
        buf_rd_q  <= '0;
        buf_cnt_q <= '0;
      end else begin
        if (rsp_keep) begin
          buf_wr_q <= buf_wr_q + PTR_W'(1);
        end
        if (pop) begin
          buf_rd_q <= buf_rd_q + PTR_W'(1);
        end
        buf_cnt_q <= buf_cnt_q + CNT_W'(rsp_keep) - CNT_W'(pop);
      end
    end
  end

  // Tag and instruction storage; contents are qualified by the pointers above.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q[tag_wr_q] <= pc_q;
    end
    if (rsp_keep) begin
      buf_data_q[buf_wr_q] <= imem_rdata;
      buf_pc_q[buf_wr_q]   <= tag_q[tag_rd_q];
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch unit and its memory.
module tb_pc_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   load_pc;
  logic [ADDR_W-1:0]      load_addr;
  logic                   redirect;
  logic [ADDR_W-1:0]      redirect_addr;
  logic                   imem_req;
  logic [ADDR_W-1:0]      imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [DATA_W-1:0]      imem_rdata;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [DATA_W-1:0]      inst_data;
  logic [ADDR_W-1:0]      inst_pc;
  logic [$clog2(DEPTH):0] outstanding;

  pc_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (32'h0),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_pc       (load_pc),
    .load_addr     (load_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .outstanding   (outstanding)
  );

  always #5 clk = ~clk;

  // Model state: in-flight requests tagged with the fetch epoch they belong
  // to, and the PCs of instructions the consumer should see, in order.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } req_t;

  req_t        m_pend[$];
  logic [31:0] m_buf[$];
  logic        m_run;
  logic [31:0] m_pc;
  int          m_epoch;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          gnt_pct, rv_pct, rdy_pct, err_pct;
  int          accept_cnt;
  logic [31:0] pop_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_buf.delete();
    m_run   = 1'b0;
    m_pc    = 32'h0;
    m_epoch = 0;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic applyStimulus(input logic ld, input logic [31:0] la,
                               input logic rd, input logic [31:0] ra);
    logic exp_req, acc, resp, pop, flush;
    req_t r;
    @(negedge clk);
    exp_req = m_run && ((m_pend.size() + m_buf.size()) < DEPTH);
    checkOutput("imem_req", imem_req, exp_req);
    if (exp_req) checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("inst_valid", inst_valid, m_buf.size() != 0);
    if (m_buf.size() != 0) begin
      checkOutput("inst_pc", inst_pc, m_buf[0]);
      checkOutput("inst_data", inst_data, mem_word(m_buf[0]));
    end
    checkOutput("outstanding", 32'(outstanding), 32'(m_pend.size()));

    imem_gnt      = ($urandom_range(99) < gnt_pct);
    inst_ready    = ($urandom_range(99) < rdy_pct);
    load_pc       = ld;
    load_addr     = la;
    redirect      = rd;
    redirect_addr = ra;
    imem_rvalid   = 1'b0;
    imem_rdata    = $urandom();
    if (m_pend.size() != 0) begin
      if ($urandom_range(99) < rv_pct) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m_pend[0].addr);
      end
    end else if ($urandom_range(99) < err_pct) begin
      imem_rvalid = 1'b1;
    end

    acc   = exp_req && imem_gnt;
    resp  = imem_rvalid && (m_pend.size() != 0);
    pop   = (m_buf.size() != 0) && inst_ready;
    flush = ld || (rd && m_run);
    if (pop) begin
      pop_log.push_back(m_buf[0]);
      void'(m_buf.pop_front());
    end
    if (resp) begin
      r = m_pend.pop_front();
      if (r.epoch == m_epoch && !flush) m_buf.push_back(r.addr);
    end
    if (acc) begin
      r.addr  = m_pc;
      r.epoch = m_epoch;
      m_pend.push_back(r);
      accept_cnt++;
    end
    if (flush) begin
      m_buf.delete();
      m_epoch++;
      m_pc = ld ? la : ra;
    end else if (acc) begin
      m_pc = m_pc + 32'd4;
    end
    if (ld) m_run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Run until the consumer has taken at least one instruction, bounded.
  task automatic run_until_pop(input int limit);
    for (int i = 0; i < limit && pop_log.size() == 0; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic resetDut();
    reset       = 1'b0;
    load_pc     = 1'b0;
    load_addr   = '0;
    redirect    = 1'b0;
    redirect_addr = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_valid", inst_valid, 1'b0);
    checkOutput("rst_outst", 32'(outstanding), 32'h0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    reset      = 1'b1;
    gnt_pct    = 100;
    rv_pct     = 100;
    rdy_pct    = 100;
    err_pct    = 0;
    accept_cnt = 0;
    pop_log.delete();
  endtask

  // Guard against a stuck simulation.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] a, b;

    // Basic fetch from 0x100 with immediate grant and response.
    resetDut();
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
    lat = 1;
    while (!inst_valid && lat < 20) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      lat++;
    end
    checkOutput("basic_latency", lat, 3);
    run_idle(6);
    checkOutput("basic_count_ok", pop_log.size() >= 3, 1'b1);
    if (pop_log.size() >= 3) begin
      checkOutput("basic_pc0", pop_log[0], 32'h100);
      checkOutput("basic_pc1", pop_log[1], 32'h104);
      checkOutput("basic_pc2", pop_log[2], 32'h108);
    end

    // Back-pressure: consumer stalled, credits run out after DEPTH accepts.
    resetDut();
    rdy_pct = 0;
    applyStimulus(1'b1, 32'h300, 1'b0, 32'h0);
    run_idle(10);
    checkOutput("bp_accepts", accept_cnt, DEPTH);
    checkOutput("bp_req_low", imem_req, 1'b0);
    rdy_pct = 100;
    run_idle(12);
    checkOutput("bp_count_ok", pop_log.size() >= 4, 1'b1);
    for (int i = 0; i < pop_log.size(); i++)
      checkOutput("bp_seq", pop_log[i], 32'h300 + 32'(4 * i));

    // Redirect with two requests outstanding drops both old responses.
    resetDut();
    rv_pct = 0;
    applyStimulus(1'b1, 32'h180, 1'b0, 32'h0);
    for (int i = 0; i < 10 && m_pend.size() < 2; i++) run_idle(1);
    checkOutput("rd_outst", 32'(outstanding), 32'h2);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h200);
    pop_log.delete();
    rv_pct = 100;
    run_until_pop(20);
    if (pop_log.size() == 0) checkOutput("rd_pop_seen", 32'h0, 32'h1);
    else checkOutput("rd_next_pc", pop_log[0], 32'h200);

    // Address wrap at the top of the address space.
    resetDut();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    run_idle(8);
    checkOutput("wrap_count_ok", pop_log.size() >= 2, 1'b1);
    if (pop_log.size() >= 2) begin
      checkOutput("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
      checkOutput("wrap_pc1", pop_log[1], 32'h0);
    end

    // load_pc and redirect together: load_pc wins.
    resetDut();
    applyStimulus(1'b1, 32'h500, 1'b0, 32'h0);
    run_idle(5);
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h80);
    pop_log.delete();
    run_until_pop(20);
    if (pop_log.size() == 0) checkOutput("conf_pop_seen", 32'h0, 32'h1);
    else checkOutput("conf_next_pc", pop_log[0], 32'h40);

    // Redirect while idle is ignored.
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 32'h80);
    checkOutput("idle_req", imem_req, 1'b0);
    checkOutput("idle_valid", inst_valid, 1'b0);

    // Reset mid-operation with one request outstanding acts immediately.
    resetDut();
    rv_pct = 0;
    applyStimulus(1'b1, 32'h600, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("mr_outst_before", 32'(outstanding), 32'h1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checkOutput("mr_req", imem_req, 1'b0);
    checkOutput("mr_valid", inst_valid, 1'b0);
    checkOutput("mr_outst", 32'(outstanding), 32'h0);
    checkOutput("mr_addr", imem_addr, 32'h0);
    @(negedge clk);
    reset   = 1'b1;
    rv_pct  = 100;
    err_pct = 50;
    run_idle(5);

    // Randomized traffic with restarts, redirects and stray responses.
    resetDut();
    err_pct = 5;
    a = $urandom();
    a[1:0] = 2'b00;
    applyStimulus(1'b1, a, 1'b0, 32'h0);
    for (int blk = 0; blk < 60; blk++) begin
      gnt_pct = $urandom_range(20, 100);
      rv_pct  = $urandom_range(20, 100);
      rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < 50; i++) begin
        a = $urandom();
        a[1:0] = 2'b00;
        b = $urandom();
        b[1:0] = 2'b00;
        applyStimulus($urandom_range(99) < 2, a, $urandom_range(99) < 5, b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter ADDR_W, 32, program-counter and memory address width.
REQ-002 Parameter DATA_W, 32, instruction width; SHALL be a multiple of 8.
REQ-003 Parameter RESET_PC, 0, PC value after reset.
REQ-004 Parameter DEPTH, 2, instruction buffer entries; SHALL be a power of 2 and at least 2.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 load_pc  in  1  start or restart fetch at load_addr.
REQ-008 load_addr  in  ADDR_W  restart address.
REQ-009 redirect  in  1  taken branch or jump; flush and refetch.
REQ-010 redirect_addr  in  ADDR_W  branch target.
REQ-011 imem_req  out  1  fetch request.
REQ-012 imem_addr  out  ADDR_W  fetch address (current PC).
REQ-013 imem_gnt  in  1  request accepted this cycle.
REQ-014 imem_rvalid  in  1  read data valid; in-order, exactly 1 per accepted request.
REQ-015 imem_rdata  in  DATA_W  instruction word.
REQ-016 inst_valid  out  1  buffered instruction available.
REQ-017 inst_ready  in  1  consumer accepts the instruction.
REQ-018 inst_data  out  DATA_W  head instruction.
REQ-019 inst_pc  out  ADDR_W  PC of head instruction.
REQ-020 outstanding  out  clog2(DEPTH)+1  requests accepted but not yet returned.

Function
REQ-021 States: IDLE (no fetch), RUN (fetching). Reset enters IDLE.
REQ-022 IDLE->RUN on load_pc=1; no other transition leaves IDLE.
REQ-023 RUN->RUN on load_pc=1: restart at load_addr, with the same flush as a redirect.
REQ-024 imem_req SHALL be 1 only in RUN and only when outstanding + buffer count < DEPTH (credit rule); the buffer therefore never overflows.
REQ-025 An accepted request (imem_req && imem_gnt) SHALL advance the PC by DATA_W/8 next cycle, wrapping modulo 2^ADDR_W.
REQ-026 imem_addr SHALL equal the PC and be combinationally stable while imem_req=1 and imem_gnt=0.
REQ-027 Each accepted request SHALL push its address into an internal in-order tag queue; on imem_rvalid, the word and its tag PC SHALL be written to the buffer.
REQ-028 outstanding SHALL increment on accept, decrement on rvalid, and stay unchanged when both occur in the same cycle.
REQ-029 inst_valid=1 iff the buffer is non-empty; a pop occurs on inst_valid && inst_ready.
REQ-030 inst_data and inst_pc SHALL hold while inst_valid=1 and inst_ready=0.
REQ-031 Push and pop in the same cycle on a full buffer SHALL both succeed.
REQ-032 Empty buffer with rvalid: inst_valid rises the next cycle, with no same-cycle bypass; minimum load-to-inst_valid latency is 3 cycles (load, req/gnt, rvalid).
REQ-033 Redirect or restart: buffer cleared next cycle; PC set to the new address; a discard counter loaded with the outstanding count (net of any same-cycle rvalid); inst_valid=0 the next cycle.
REQ-034 While discard > 0, each rvalid SHALL decrement discard and the data SHALL be dropped; new requests may issue meanwhile, and credit counts discarded requests.
REQ-035 redirect in the same cycle as an accept: the accepted request is counted as outstanding and its response discarded.
REQ-036 load_pc and redirect in the same cycle: load_pc wins.
REQ-037 redirect in IDLE SHALL be ignored.
REQ-038 imem_rvalid while outstanding=0 is a protocol error; it SHALL be ignored with no state change.

Reset
REQ-039 reset=0 asynchronously forces: state=IDLE, PC=RESET_PC, buffer empty, discard=0, outstanding=0, imem_req=0, inst_valid=0.
REQ-040 Reset asserted mid-operation SHALL abandon all in-flight requests; responses after deassertion are protocol errors (REQ-038).
REQ-041 Deassertion is synchronised by the integrator; the block requires no cycles after deassertion before load_pc is honoured.

Verification
REQ-042 Basic fetch: reset, then load_pc with load_addr=0x100, gnt=1, 1-cycle rvalid, inst_ready=1 -> inst_pc sequence 0x100, 0x104, 0x108; first inst_valid 3 cycles after load_pc.
REQ-043 Back-pressure: DEPTH=2, inst_ready=0 -> at most 2 accepts, then imem_req=0; raise inst_ready -> fetch resumes with no lost or duplicated PCs.
REQ-044 Redirect with 2 outstanding: redirect_addr=0x200 -> both old responses dropped, next inst_pc=0x200.
REQ-045 Wrap: ADDR_W=8, load_addr=0xFC -> inst_pc 0xFC then 0x00.
REQ-046 Conflicts: load_pc=1 (addr 0x40) with redirect=1 (addr 0x80) -> next inst_pc=0x40; redirect in IDLE -> imem_req stays 0.
REQ-047 Mid-run reset: assert reset with 1 outstanding -> all outputs at reset values immediately (asynchronously, without waiting for a clock edge).
